// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO and models MD latency
// with a busy down-counter so the hazard unit can stall dependent MD instructions.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_hi_t, r_lo_t;
    logic            r_wr;

    logic            w_accept, w_is_mul, w_is_div, w_done;
    logic [63:0]     w_mul_a, w_mul_b, w_prod;
    logic            w_a_neg, w_b_neg;
    logic [31:0]     w_amag, w_bsafe, w_q, w_r, w_qs, w_rs;

    assign w_accept = Start && !Req && (r_state == S_IDLE) &&
                      (MDUOp >= OP_MULT) && (MDUOp <= OP_MTLO);
    assign w_is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign w_is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign w_done   = (r_state == S_RUN) && (r_cnt == CW'(1));

    // Result is computed at acceptance; the busy period only models latency.
    assign w_mul_a = {{32{(MDUOp == OP_MULT) & A[31]}}, A};
    assign w_mul_b = {{32{(MDUOp == OP_MULT) & B[31]}}, B};
    assign w_prod  = w_mul_a * w_mul_b;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign, and 0x80000000 / -1 falls out as 0x80000000.
    assign w_a_neg = (MDUOp == OP_DIV) && A[31];
    assign w_b_neg = (MDUOp == OP_DIV) && B[31];
    assign w_amag  = w_a_neg ? (32'd0 - A) : A;
    assign w_bsafe = (B == 32'd0) ? 32'd1 : (w_b_neg ? (32'd0 - B) : B);
    assign w_q     = w_amag / w_bsafe;
    assign w_r     = w_amag % w_bsafe;
    assign w_qs    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q) : w_q;
    assign w_rs    = w_a_neg ? (32'd0 - w_r) : w_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (w_is_mul || w_is_div)) w_state_nxt = S_RUN;
            S_RUN:  if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hi_t <= '0;
            r_lo_t <= '0;
            r_wr   <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_cnt  <= CW'(MULT_CYCLES);
            r_hi_t <= w_prod[63:32];
            r_lo_t <= w_prod[31:0];
            r_wr   <= 1'b1;
        end else if (w_accept && w_is_div) begin
            r_cnt  <= CW'(DIV_CYCLES);
            r_hi_t <= w_rs;
            r_lo_t <= w_qs;
            r_wr   <= (B != 32'd0);
        end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (w_accept && (MDUOp == OP_MTHI)) begin
            HI <= A;
        end else if (w_accept && (MDUOp == OP_MTLO)) begin
            LO <= A;
        end else if (w_done && r_wr) begin
            HI <= r_hi_t;
            LO <= r_lo_t;
        end
    end

    assign Busy = (r_state == S_RUN);

endmodule
